muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine with architectural HI/LO registers. It sits beside the single-cycle ALU in EX.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the pipeline through a start/busy/done handshake.
- Iterates one bit per cycle and writes the 64-bit result into HI/LO.
- Drives a stall request so the pipeline holds instructions that read HI/LO while an operation is in flight.

---
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Multi-cycle multiply/divide engine with the architectural HI/LO registers.
//   It sits beside the single-cycle ALU in EX. Each accepted mul/div runs one
//   bit per cycle (shift-add multiply, restoring divide) on operand magnitudes.
//   A final FIX cycle applies the recorded signs and writes HI/LO.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   md_start     issue md_op this cycle (taken only when idle)
//   md_op        0 none, 1 multu, 2 mult, 3 divu, 4 div, 5 mthi, 6 mtlo, 7 none
//   md_a_data    rs: multiplicand / dividend / mthi-mtlo source
//   md_b_data    rt: multiplier / divisor
//   md_flush     abort the in-flight operation; wins over md_start
//   md_busy      engine iterating (RUN or FIX); new starts are ignored
//   md_done      one-cycle pulse after a mul/div has written HI/LO
//   md_stall     pipeline hold request for HI/LO readers (covers issue cycle)
//   md_hi/md_lo  HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             md_start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] md_a_data,
   input  logic [WIDTH-1:0] md_b_data,
   input  logic             md_flush,
   output logic             md_busy,
   output logic             md_done,
   output logic             md_stall,
   output logic [WIDTH-1:0] md_hi,
   output logic [WIDTH-1:0] md_lo
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt;
   // r_acc: upper product half (mul) or partial remainder (div).
   // r_q:   lower product half / multiplier (mul) or dividend->quotient (div).
   logic [WIDTH-1:0]   r_acc, r_q, r_opb;
   logic               r_is_div, r_neg_q, r_neg_r;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_done;

   logic               w_is_md, w_signed, w_accept;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_sum, w_shrem;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_prod, w_prod_fix;
   logic [WIDTH-1:0]   w_quo, w_rem;

   assign w_is_md  = (md_op >= 3'd1) && (md_op <= 3'd4);
   assign w_signed = (md_op == 3'd2) || (md_op == 3'd4);
   assign w_accept = md_start && !md_flush && (r_state == S_IDLE);
   assign w_abs_a  = (w_signed && md_a_data[WIDTH-1]) ? -md_a_data : md_a_data;
   assign w_abs_b  = (w_signed && md_b_data[WIDTH-1]) ? -md_b_data : md_b_data;

   // Multiply step: conditional add into the upper half, carry kept in bit WIDTH
   // so the right shift of the whole product does not lose it.
   assign w_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : '0);

   // Divide step: the shifted remainder can need WIDTH+1 bits. When the trial
   // subtraction succeeds the result is below the divisor, so WIDTH bits hold it.
   assign w_shrem = {r_acc, r_q[WIDTH-1]};
   assign w_ge    = (w_shrem >= {1'b0, r_opb});
   assign w_diff  = w_shrem[WIDTH-1:0] - r_opb;

   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
   assign w_quo      = r_neg_q ? -r_q : r_q;
   assign w_rem      = r_neg_r ? -r_acc : r_acc;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_is_md) w_next = S_RUN;
         S_RUN: begin
            if (md_flush)                            w_next = S_IDLE;
            else if (r_cnt == CNT_W'(WIDTH - 1))     w_next = S_FIX;
         end
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_opb    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  case (md_op)
                     3'd1, 3'd2, 3'd3, 3'd4: begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_q      <= w_abs_a;
                        r_opb    <= w_abs_b;
                        r_is_div <= (md_op == 3'd3) || (md_op == 3'd4);
                        r_neg_q  <= w_signed && (md_a_data[WIDTH-1] ^ md_b_data[WIDTH-1]);
                        r_neg_r  <= w_signed && md_a_data[WIDTH-1];
                     end
                     3'd5:    r_hi <= md_a_data;
                     3'd6:    r_lo <= md_a_data;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (!md_flush) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_is_div) begin
                     r_acc <= w_ge ? w_diff : w_shrem[WIDTH-1:0];
                     r_q   <= {r_q[WIDTH-2:0], w_ge};
                  end else begin
                     r_acc <= w_sum[WIDTH:1];
                     r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                  end
               end
            end
            S_FIX: begin
               if (!md_flush) begin
                  if (r_is_div) begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end else begin
                     {r_hi, r_lo} <= w_prod_fix;
                  end
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign md_busy  = (r_state != S_IDLE);
   assign md_done  = r_done;
   assign md_stall = md_busy || (md_start && w_is_md);
   assign md_hi    = r_hi;
   assign md_lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        md_start, md_flush;
   logic [2:0]  md_op;
   logic [31:0] md_a_data, md_b_data;
   logic        md_busy, md_done, md_stall;
   logic [31:0] md_hi, md_lo;

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] exp_hi = '0, exp_lo = '0;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_op(md_op),
      .md_a_data(md_a_data), .md_b_data(md_b_data), .md_flush(md_flush),
      .md_busy(md_busy), .md_done(md_done), .md_stall(md_stall),
      .md_hi(md_hi), .md_lo(md_lo)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Reference: arithmetic on magnitudes, then sign rules; divide by zero
   // yields an all-ones quotient magnitude and the dividend magnitude as remainder.
   function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b);
      longint sa, sb;
      logic [31:0] ma, mb, q, r;
      logic sg;
      sg = (op == 3'd4);
      case (op)
         3'd1: return {32'b0, a} * {32'b0, b};
         3'd2: begin sa = $signed(a); sb = $signed(b); return sa * sb; end
         default: begin
            ma = (sg && a[31]) ? -a : a;
            mb = (sg && b[31]) ? -b : b;
            q  = (mb == 0) ? 32'hFFFF_FFFF : ma / mb;
            r  = (mb == 0) ? ma : ma % mb;
            if (sg && (a[31] ^ b[31])) q = -q;
            if (sg && a[31]) r = -r;
            return {r, q};
         end
      endcase
   endfunction

   // Issue a mul/div at the current negedge and follow it to its done cycle.
   // Returns at the negedge inside the md_done cycle, so a caller may issue again.
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, b, input string tag);
      logic [63:0] e;
      int nb, bad;
      e = model(op, a, b);
      md_start = 1'b1; md_op = op; md_a_data = a; md_b_data = b;
      #1;
      vectors++;
      if (md_stall !== 1'b1) begin
         miscompares++; $display("FAIL %s issue_stall got=%b want=1", tag, md_stall);
      end
      @(negedge clk);
      md_start = 1'b0; md_op = 3'd0;
      nb = 0; bad = 0;
      while (md_busy === 1'b1 && nb < 100) begin
         nb++;
         if (md_stall !== 1'b1 || md_done !== 1'b0) bad++;
         @(negedge clk);
      end
      vectors++;
      if (nb != 33) begin
         miscompares++; $display("FAIL %s busy_cycles got=%0d want=33", tag, nb);
      end
      vectors++;
      if (bad != 0) begin
         miscompares++; $display("FAIL %s stall_or_early_done got=%0d bad cycles want=0", tag, bad);
      end
      vectors++;
      if (md_done !== 1'b1) begin
         miscompares++; $display("FAIL %s done_pulse got=%b want=1", tag, md_done);
      end
      vectors++;
      if ({md_hi, md_lo} !== e) begin
         miscompares++;
         $display("FAIL %s result op=%0d a=%h b=%h got=%h_%h want=%h_%h",
                  tag, op, a, b, md_hi, md_lo, e[63:32], e[31:0]);
      end
      exp_hi = e[63:32]; exp_lo = e[31:0];
   endtask

   task automatic test_reset();
      rst_n = 1'b0; md_start = 1'b0; md_flush = 1'b0; md_op = '0;
      md_a_data = '0; md_b_data = '0;
      #12;
      vectors++;
      if ({md_hi, md_lo, md_busy, md_done, md_stall} !== 67'b0) begin
         miscompares++;
         $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b want all 0",
                  md_hi, md_lo, md_busy, md_done, md_stall);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mul();
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      @(negedge clk);
      vectors++;
      if (md_done !== 1'b0) begin
         miscompares++; $display("FAIL multu_done_width got=%b want=0", md_done);
      end
      do_op(3'd2, 32'hFFFF_FFFD, 32'd7, "mult_neg");
   endtask

   task automatic test_back_to_back();
      // Issued inside the done cycle of the previous MULT.
      do_op(3'd2, 32'h8000_0000, 32'h8000_0000, "b2b_mult");
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "b2b_div");
   endtask

   task automatic test_div();
      @(negedge clk);
      do_op(3'd3, 32'd100, 32'd7, "divu_small");
      @(negedge clk);
      do_op(3'd3, 32'h1234_5678, 32'd0, "divu_by_zero");
      @(negedge clk);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      @(negedge clk);
      do_op(3'd4, 32'h0000_0064, 32'hFFFF_FFF9, "div_neg_divisor");
   endtask

   task automatic test_mthi_mtlo();
      @(negedge clk);
      md_start = 1'b1; md_op = 3'd5; md_a_data = 32'hA5A5_A5A5;
      #1;
      vectors++;
      if (md_stall !== 1'b0) begin
         miscompares++; $display("FAIL mthi_stall got=%b want=0", md_stall);
      end
      @(negedge clk); md_start = 1'b0;
      vectors++;
      if (md_hi !== 32'hA5A5_A5A5 || md_busy !== 1'b0 || md_done !== 1'b0) begin
         miscompares++;
         $display("FAIL mthi_write got hi=%h busy=%b done=%b want hi=a5a5a5a5 busy=0 done=0",
                  md_hi, md_busy, md_done);
      end
      exp_hi = 32'hA5A5_A5A5;
      // Start a DIVU, then try MTLO/MTHI while busy: both must be dropped.
      md_start = 1'b1; md_op = 3'd3; md_a_data = 32'd1000; md_b_data = 32'd3;
      @(negedge clk);
      md_op = 3'd6; md_a_data = 32'h5A5A_5A5A;
      @(negedge clk);
      md_op = 3'd5; md_a_data = 32'h1111_2222;
      @(negedge clk);
      md_start = 1'b0; md_op = 3'd0;
      vectors++;
      if (md_lo !== exp_lo || md_hi !== exp_hi || md_stall !== 1'b1) begin
         miscompares++;
         $display("FAIL move_while_busy got hi=%h lo=%h stall=%b want hi=%h lo=%h stall=1",
                  md_hi, md_lo, md_stall, exp_hi, exp_lo);
      end
      for (int i = 0; i < 40 && md_done !== 1'b1; i++) @(negedge clk);
      vectors++;
      if (md_done !== 1'b1 || md_lo !== 32'd333 || md_hi !== 32'd1) begin
         miscompares++;
         $display("FAIL divu_after_moves got done=%b hi=%h lo=%h want done=1 hi=1 lo=14d",
                  md_done, md_hi, md_lo);
      end
      exp_hi = 32'd1; exp_lo = 32'd333;
   endtask

   task automatic test_flush();
      int dn;
      @(negedge clk);
      // Flush beats start when idle.
      md_start = 1'b1; md_flush = 1'b1; md_op = 3'd1; md_a_data = 32'd9; md_b_data = 32'd9;
      @(negedge clk);
      md_start = 1'b0; md_flush = 1'b0;
      vectors++;
      if (md_busy !== 1'b0) begin
         miscompares++; $display("FAIL flush_over_start busy got=%b want=0", md_busy);
      end
      md_start = 1'b1; md_op = 3'd1; md_a_data = 32'hDEAD_BEEF; md_b_data = 32'h1234_5678;
      @(negedge clk); md_start = 1'b0;
      repeat (10) @(negedge clk);
      md_flush = 1'b1;
      @(negedge clk); md_flush = 1'b0;
      vectors++;
      if (md_busy !== 1'b0 || md_hi !== exp_hi || md_lo !== exp_lo) begin
         miscompares++;
         $display("FAIL flush_run got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                  md_busy, md_hi, md_lo, exp_hi, exp_lo);
      end
      dn = 0;
      repeat (40) begin @(negedge clk); if (md_done !== 1'b0) dn++; end
      vectors++;
      if (dn != 0 || md_hi !== exp_hi || md_lo !== exp_lo) begin
         miscompares++;
         $display("FAIL flush_no_done got done_cycles=%0d hi=%h lo=%h want 0 %h %h",
                  dn, md_hi, md_lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = -32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         do_op(op, a, b, "random");
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      md_start = 1'b1; md_op = 3'd1; md_a_data = 32'h7; md_b_data = 32'h9;
      @(negedge clk); md_start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({md_hi, md_lo, md_busy, md_done} !== 66'b0) begin
         miscompares++;
         $display("FAIL async_reset got hi=%h lo=%h busy=%b done=%b want all 0",
                  md_hi, md_lo, md_busy, md_done);
      end
      @(negedge clk); rst_n = 1'b1;
      exp_hi = '0; exp_lo = '0;
      @(negedge clk);
      do_op(3'd3, 32'd100, 32'd7, "after_reset");
   endtask

   initial begin
      test_reset();
      test_mul();
      test_back_to_back();
      test_div();
      test_mthi_mtlo();
      test_flush();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
